// File: rtl/haze_atmo_light_ctrl.sv
// Atmospheric light controller for the haze-removal pipeline.
// During a frame it tracks the brightest dark-channel pixel and keeps the
// brightest colour component of the source pixel at that location. At end of
// frame it smooths, clamps and commits a new A. A frame with bad geometry
// does not update A.
module haze_atmo_light_ctrl #(
    parameter int         IMG_W  = 640,
    parameter int         IMG_H  = 480,
    parameter logic [7:0] A_INIT = 8'd200,
    parameter logic [7:0] A_MIN  = 8'd64,
    parameter logic [7:0] A_MAX  = 8'd250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vsync,
    input  logic        in_href,
    input  logic        in_clken,
    input  logic [7:0]  in_dark,
    input  logic [23:0] in_img,
    input  logic        cfg_smooth_en,
    input  logic        cfg_freeze,
    output logic [7:0]  A_out,
    output logic        A_valid,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [15:0] LINE_PIX    = 16'(IMG_W);
    localparam logic [15:0] FRAME_LINES = 16'(IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        CALC,
        COMMIT
    } state_t;

    state_t      state_q;
    logic        vsyncPrev_q;
    logic        hrefPrev_q;
    logic        pending_q;
    logic        err_q;
    logic [7:0]  maxDark_q;
    logic [7:0]  cand_q;
    logic [15:0] pixCnt_q;
    logic [15:0] lineCnt_q;
    logic [7:0]  aCalc_q;
    logic [7:0]  aOut_q;
    logic        aValid_q;
    logic        frameDone_q;
    logic        frameErr_q;

    logic        vsyncRise;
    logic        vsyncFall;
    logic        hrefFall;
    logic        pixelValid;
    logic [7:0]  pixMax;
    logic [15:0] lineCntEnd;
    logic        err_d;
    logic [9:0]  smoothSum;
    logic [7:0]  aRaw;
    logic [7:0]  aCalc_d;

    assign vsyncRise  = in_vsync & ~vsyncPrev_q;
    assign vsyncFall  = ~in_vsync & vsyncPrev_q;
    assign hrefFall   = ~in_href & hrefPrev_q;
    assign pixelValid = in_clken & in_href;
    // A line ending on the same cycle as the frame counts toward the line total.
    assign lineCntEnd = hrefFall ? (lineCnt_q + 16'd1) : lineCnt_q;

    // Brightest colour component of the current source pixel.
    always_comb begin
        pixMax = in_img[23:16];
        if (in_img[15:8] > pixMax) begin
            pixMax = in_img[15:8];
        end
        if (in_img[7:0] > pixMax) begin
            pixMax = in_img[7:0];
        end
    end

    // Accumulate geometry errors: short/long lines and wrong line count.
    always_comb begin
        err_d = err_q;
        if (hrefFall && (pixCnt_q != LINE_PIX)) begin
            err_d = 1'b1;
        end
        if (vsyncFall && (lineCntEnd != FRAME_LINES)) begin
            err_d = 1'b1;
        end
    end

    // Candidate A: optional 3:1 IIR blend with the current A, then clamp.
    always_comb begin
        smoothSum = {2'b00, aOut_q} + {1'b0, aOut_q, 1'b0} + {2'b00, cand_q} + 10'd2;
        aRaw      = (cfg_smooth_en && aValid_q) ? smoothSum[9:2] : cand_q;
        aCalc_d   = aRaw;
        if (aRaw < A_MIN) begin
            aCalc_d = A_MIN;
        end else if (aRaw > A_MAX) begin
            aCalc_d = A_MAX;
        end
    end

    // Frame FSM with all trackers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vsyncPrev_q <= 1'b0;
            hrefPrev_q  <= 1'b0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            maxDark_q   <= 8'd0;
            cand_q      <= 8'd0;
            pixCnt_q    <= 16'd0;
            lineCnt_q   <= 16'd0;
            aCalc_q     <= 8'd0;
            aOut_q      <= A_INIT;
            aValid_q    <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            vsyncPrev_q <= in_vsync;
            hrefPrev_q  <= in_href;
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vsyncRise) begin
                        state_q   <= ACTIVE;
                        maxDark_q <= 8'd0;
                        cand_q    <= 8'd0;
                        pixCnt_q  <= 16'd0;
                        lineCnt_q <= 16'd0;
                        err_q     <= 1'b0;
                    end
                end
                ACTIVE: begin
                    err_q <= err_d;
                    if (pixelValid) begin
                        pixCnt_q <= pixCnt_q + 16'd1;
                        if (in_dark > maxDark_q) begin
                            maxDark_q <= in_dark;
                            cand_q    <= pixMax;
                        end
                    end
                    if (hrefFall) begin
                        lineCnt_q <= lineCnt_q + 16'd1;
                        pixCnt_q  <= 16'd0;
                    end
                    if (vsyncFall) begin
                        state_q   <= CALC;
                        pending_q <= 1'b0;
                    end
                end
                CALC: begin
                    aCalc_q <= aCalc_d;
                    if (vsyncRise) begin
                        pending_q <= 1'b1;
                    end
                    state_q <= COMMIT;
                end
                COMMIT: begin
                    if (!err_q && !cfg_freeze) begin
                        aOut_q   <= aCalc_q;
                        aValid_q <= 1'b1;
                    end
                    frameErr_q  <= err_q;
                    frameDone_q <= 1'b1;
                    if (pending_q || vsyncRise) begin
                        // The new frame started while we were busy; its
                        // first pixels were dropped, so it cannot be trusted.
                        state_q   <= ACTIVE;
                        maxDark_q <= 8'd0;
                        cand_q    <= 8'd0;
                        pixCnt_q  <= 16'd0;
                        lineCnt_q <= 16'd0;
                        err_q     <= 1'b1;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign A_out      = aOut_q;
    assign A_valid    = aValid_q;
    assign frame_done = frameDone_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_haze_atmo_light_ctrl.sv
// Testbench for haze_atmo_light_ctrl with a small frame geometry.
// Frames are built from random pixel data; the expected A is derived per frame
// from the pixels actually driven, using plain arithmetic.
module tb_haze_atmo_light_ctrl;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk;
    logic        rst;
    logic        in_vsync;
    logic        in_href;
    logic        in_clken;
    logic [7:0]  in_dark;
    logic [23:0] in_img;
    logic        cfg_smooth_en;
    logic        cfg_freeze;
    logic [7:0]  A_out;
    logic        A_valid;
    logic        frame_done;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    int expA     = 200;
    bit expValid = 0;
    bit expErr   = 0;
    bit pendingHigh = 0;

    logic [7:0]  frameDark [0:63];
    logic [23:0] frameImg  [0:63];

    haze_atmo_light_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .A_INIT(8'd200),
        .A_MIN (8'd64),
        .A_MAX (8'd250)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vsync     (in_vsync),
        .in_href      (in_href),
        .in_clken     (in_clken),
        .in_dark      (in_dark),
        .in_img       (in_img),
        .cfg_smooth_en(cfg_smooth_en),
        .cfg_freeze   (cfg_freeze),
        .A_out        (A_out),
        .A_valid      (A_valid),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int max3(input logic [23:0] px);
        int m;
        m = int'(px[23:16]);
        if (int'(px[15:8]) > m) m = int'(px[15:8]);
        if (int'(px[7:0]) > m) m = int'(px[7:0]);
        return m;
    endfunction

    // Reference rule for the next committed A.
    function automatic int nextA(input int prevA, input bit prevValid, input int cand, input bit smooth);
        int a;
        a = (smooth && prevValid) ? (3 * prevA + cand + 2) / 4 : cand;
        if (a < 64) a = 64;
        if (a > 250) a = 250;
        return a;
    endfunction

    // Random frame content with all dark values below plantDark, plus one planted pixel.
    task automatic fillFrame(input int plantIdx, input int plantDark, input logic [23:0] plantImg);
        for (int i = 0; i < 64; i++) begin
            frameDark[i] = (plantDark == 0) ? 8'd0 : 8'($urandom_range(plantDark - 1, 0));
            frameImg[i]  = 24'($urandom);
        end
        if (plantIdx >= 0) begin
            frameDark[plantIdx] = 8'(plantDark);
            frameImg[plantIdx]  = plantImg;
        end
    endtask

    // Drive one frame, then check the commit timing and result.
    task automatic applyStimulus(input int nLines, input int shortLine, input bit smooth,
                                 input bit freeze, input bit lastTogether, input bit reRise);
        int maxD;
        int cand;
        int n;
        int prevA;
        bit good;
        maxD = 0;
        cand = 0;
        good = !pendingHigh;
        cfg_smooth_en = smooth;
        cfg_freeze    = freeze;
        if (!pendingHigh) begin
            @(negedge clk);
            in_vsync = 1'b1;
        end
        pendingHigh = 0;
        repeat (2) @(negedge clk);
        checkOutput("aHeldInFrame", int'(A_out), expA);
        for (int l = 0; l < nLines; l++) begin
            n = (l == shortLine) ? W - 1 : W;
            if (n != W) good = 0;
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(3, 0) == 0) begin
                    @(negedge clk);
                    in_href  = 1'b1;
                    in_clken = 1'b0;
                end
                @(negedge clk);
                in_href  = 1'b1;
                in_clken = 1'b1;
                in_dark  = frameDark[l * W + p];
                in_img   = frameImg[l * W + p];
                if (int'(in_dark) > maxD) begin
                    maxD = int'(in_dark);
                    cand = max3(in_img);
                end
            end
            @(negedge clk);
            in_href  = 1'b0;
            in_clken = 1'b0;
            if (l == nLines - 1) begin
                if (lastTogether) in_vsync = 1'b0;
            end else begin
                @(negedge clk);
                if ($urandom_range(1, 0) == 1) begin
                    in_clken = 1'b1;
                    in_dark  = 8'd255;
                    in_img   = 24'hFFFFFF;
                    @(negedge clk);
                    in_clken = 1'b0;
                end
            end
        end
        if (nLines != H) good = 0;
        if (!lastTogether) begin
            @(negedge clk);
            in_vsync = 1'b0;
        end
        prevA = expA;
        @(negedge clk);
        checkOutput("doneEarly1", int'(frame_done), 0);
        if (reRise) in_vsync = 1'b1;
        @(negedge clk);
        checkOutput("doneEarly2", int'(frame_done), 0);
        checkOutput("aBeforeCommit", int'(A_out), prevA);
        if (good && !freeze) begin
            expA     = nextA(expA, expValid, cand, smooth);
            expValid = 1;
        end
        expErr = !good;
        @(negedge clk);
        checkOutput("doneAtCommit", int'(frame_done), 1);
        checkOutput("aCommitted", int'(A_out), expA);
        checkOutput("aValid", int'(A_valid), int'(expValid));
        checkOutput("frameErr", int'(frame_err), int'(expErr));
        pendingHigh = reRise;
        @(negedge clk);
        checkOutput("doneOneCycle", int'(frame_done), 0);
    endtask

    initial begin
        int doneSeen;
        int nL;
        int sL;
        rst = 1'b1;
        in_vsync = 1'b0;
        in_href = 1'b0;
        in_clken = 1'b0;
        in_dark = 8'd0;
        in_img = 24'd0;
        cfg_smooth_en = 1'b0;
        cfg_freeze = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstA", int'(A_out), 200);
        checkOutput("rstValid", int'(A_valid), 0);
        checkOutput("rstDone", int'(frame_done), 0);
        checkOutput("rstErr", int'(frame_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single brightest dark pixel at line 2, pixel 5.
        fillFrame(2 * W + 5, 180, {8'd230, 8'd120, 8'd90});
        applyStimulus(H, -1, 0, 0, 0, 0);
        checkOutput("planA", int'(A_out), 230);

        // Smoothing from A=200 toward 240, then toward 20.
        fillFrame($urandom_range(H * W - 1, 0), 200, {8'd200, 8'd10, 8'd10});
        applyStimulus(H, -1, 0, 0, 0, 0);
        fillFrame($urandom_range(H * W - 1, 0), 250, {8'd10, 8'd240, 8'd5});
        applyStimulus(H, -1, 1, 0, 0, 0);
        checkOutput("smoothUp", int'(A_out), 210);
        fillFrame($urandom_range(H * W - 1, 0), 250, {8'd3, 8'd7, 8'd20});
        applyStimulus(H, -1, 1, 0, 1, 0);
        checkOutput("smoothDown", int'(A_out), 163);

        // Clamping at both ends.
        fillFrame(3, 99, {8'd255, 8'd0, 8'd0});
        applyStimulus(H, -1, 0, 0, 0, 0);
        checkOutput("clampHigh", int'(A_out), 250);
        fillFrame(-1, 0, 24'd0);
        applyStimulus(H, -1, 0, 0, 0, 0);
        checkOutput("clampLow", int'(A_out), 64);

        // Short line, then a good frame ending line and frame together.
        fillFrame(9, 200, {8'd180, 8'd0, 8'd0});
        applyStimulus(H, 1, 0, 0, 0, 0);
        checkOutput("shortLineA", int'(A_out), 64);
        fillFrame(12, 200, {8'd0, 8'd0, 8'd180});
        applyStimulus(H, -1, 0, 0, 1, 0);
        checkOutput("recoverA", int'(A_out), 180);

        // Equal dark maxima: the first location wins.
        fillFrame(-1, 150, 24'd0);
        frameDark[1] = 8'd150;
        frameImg[1]  = {8'd100, 8'd50, 8'd0};
        frameDark[6] = 8'd150;
        frameImg[6]  = {8'd10, 8'd220, 8'd30};
        applyStimulus(H, -1, 0, 0, 0, 0);
        checkOutput("tieFirst", int'(A_out), 100);
        fillFrame(5, 200, {8'd0, 8'd0, 8'd180});
        applyStimulus(H, -1, 0, 1, 0, 0);
        checkOutput("freezeHold", int'(A_out), 100);

        // Reset in the middle of a frame.
        @(negedge clk);
        in_vsync = 1'b1;
        repeat (2) @(negedge clk);
        in_href = 1'b1;
        in_clken = 1'b1;
        in_dark = 8'd250;
        in_img = 24'h505050;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        in_vsync = 1'b0;
        in_href = 1'b0;
        in_clken = 1'b0;
        @(negedge clk);
        checkOutput("midRstA", int'(A_out), 200);
        checkOutput("midRstValid", int'(A_valid), 0);
        rst = 1'b0;
        expA = 200;
        expValid = 0;
        expErr = 0;
        doneSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) doneSeen++;
        end
        checkOutput("midRstNoDone", doneSeen, 0);

        // Vsync rises again one cycle after it fell.
        fillFrame(20, 200, {8'd120, 8'd0, 8'd0});
        applyStimulus(H, -1, 1, 0, 0, 1);
        checkOutput("reRisePrevA", int'(A_out), 120);
        fillFrame(4, 200, {8'd240, 8'd0, 8'd0});
        applyStimulus(H, -1, 0, 0, 0, 0);
        checkOutput("reRiseErr", int'(frame_err), 1);
        checkOutput("reRiseHoldA", int'(A_out), 120);

        // Random frames with random configuration and geometry faults.
        for (int i = 0; i < 24; i++) begin
            nL = H;
            sL = -1;
            case ($urandom_range(5, 0))
                0: sL = $urandom_range(H - 1, 0);
                1: nL = H - 1;
                2: nL = H + 1;
                default: ;
            endcase
            fillFrame($urandom_range(nL * W - 1, 0), $urandom_range(255, 0), 24'($urandom));
            applyStimulus(nL, sL, 1'($urandom_range(1, 0)), ($urandom_range(5, 0) == 0),
                          1'($urandom_range(1, 0)), (i < 23) && ($urandom_range(7, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
